// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 data-memory path: FSM encoding, word width,
// error causes and the request classifier used at acceptance.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ALIGN    = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_CONFLICT = 2'd3
  } err_cause_e;

  // Full 30-bit word-index compare so high address bits can never alias into range.
  function automatic err_cause_e classify(input logic        rd,
                                          input logic        wr,
                                          input logic [31:0] addr,
                                          input logic [31:0] depth);
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if ({2'b00, addr[31:2]} >= depth) return ERR_RANGE;
    if (rd && wr) return ERR_CONFLICT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, combinational read, synchronous clear of every word.
// Clear has priority over a write on the same edge.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clock,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [3:0]        led_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign led_o   = mem_q[0][3:0];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle LEGv8 data-memory responder: IDLE/BUSY/DONE FSM, one-cycle ready pulse, error flag.
// Optional load/store completion counters are built when DMEM_STATS_EN is defined.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int AW      = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic [3:0]        mLED,
  output logic [15:0]       rdCount,
  output logic [15:0]       wrCount
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  err_cause_e        cause_q, cause_d;
  logic [3:0]        mled_q;

  logic [WORD_W-1:0] arr_rdata;
  logic [3:0]        arr_led;
  logic              done;
  logic              ok;
  logic              commit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cause_q <= ERR_NONE;
      mled_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cause_q <= cause_d;
      mled_q  <= arr_led;
    end
  end

  // cnt_q holds the BUSY cycles still to run; the last one hands over to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (memRead || memWrite) begin
          idx_d   = addr[AW+1:2];
          wdata_d = wdata;
          wr_d    = memWrite;
          cause_d = classify(memRead, memWrite, addr, 32'(DEPTH));
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done   = (state_q == DONE);
  assign ok     = (cause_q == ERR_NONE);
  assign commit = done && ok && wr_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .clear_i (reset),
    .we_i    (commit),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (arr_rdata),
    .led_o   (arr_led)
  );

  assign ready = done;
  assign err   = done && !ok;
  assign rdata = (done && ok) ? arr_rdata : '0;
  assign mLED  = mled_q;

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (done && ok) begin
      if (wr_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rdCount = rd_cnt_q;
  assign wrCount = wr_cnt_q;
`else
  assign rdCount = '0;
  assign wrCount = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 3) against a cycle-stamped
// transaction model, plus directed accesses with literal expectations.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] wd_s   [3];
  logic [31:0] rdata_o[3];
  logic        ready_o[3];
  logic        err_o  [3];
  logic [3:0]  led_o  [3];
  logic [15:0] rdc_o  [3];
  logic [15:0] wrc_o  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2), .AW(6)) dut0 (
    .clock(clock), .reset(reset), .memRead(rd_s[0]), .memWrite(wr_s[0]),
    .addr(addr_s[0]), .wdata(wd_s[0]), .rdata(rdata_o[0]), .ready(ready_o[0]),
    .err(err_o[0]), .mLED(led_o[0]), .rdCount(rdc_o[0]), .wrCount(wrc_o[0]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .AW(6)) dut1 (
    .clock(clock), .reset(reset), .memRead(rd_s[1]), .memWrite(wr_s[1]),
    .addr(addr_s[1]), .wdata(wd_s[1]), .rdata(rdata_o[1]), .ready(ready_o[1]),
    .err(err_o[1]), .mLED(led_o[1]), .rdCount(rdc_o[1]), .wrCount(wrc_o[1]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(3), .AW(6)) dut2 (
    .clock(clock), .reset(reset), .memRead(rd_s[2]), .memWrite(wr_s[2]),
    .addr(addr_s[2]), .wdata(wd_s[2]), .rdata(rdata_o[2]), .ready(ready_o[2]),
    .err(err_o[2]), .mLED(led_o[2]), .rdCount(rdc_o[2]), .wrCount(wrc_o[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Transaction model: a request accepted at edge stamp A is visible as ready
  // during the cycle after edge A+L-1 and takes effect on edge A+L.
  logic [31:0] mmem [3][DEPTH];
  bit          pend [3];
  int          acc  [3];
  bit          op_wr[3];
  bit          op_err[3];
  int          op_idx[3];
  logic [31:0] op_wd[3];
  logic [31:0] op_rd[3];
  logic [3:0]  mled [3];
  logic [15:0] mrdc [3];
  logic [15:0] mwrc [3];
  int          cyc = 0;
  bit          armed = 1'b0;

  always @(posedge clock) begin
    logic [3:0] led_next;
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        armed   = 1'b1;
        pend[d] = 1'b0;
        mled[d] = 4'h0;
        mrdc[d] = 16'h0;
        mwrc[d] = 16'h0;
        for (int i = 0; i < DEPTH; i++) mmem[d][i] = 32'h0;
      end else begin
        led_next = mmem[d][0][3:0];
        if (pend[d] && cyc == acc[d] + lat_of(d)) begin
          if (!op_err[d]) begin
            if (op_wr[d]) begin
              mmem[d][op_idx[d]] = op_wd[d];
              mwrc[d] = mwrc[d] + 16'h1;
            end else begin
              mrdc[d] = mrdc[d] + 16'h1;
            end
          end
          pend[d] = 1'b0;
        end else if (!pend[d] && (rd_s[d] || wr_s[d])) begin
          pend[d]   = 1'b1;
          acc[d]    = cyc;
          op_wr[d]  = wr_s[d];
          op_wd[d]  = wd_s[d];
          op_err[d] = (addr_s[d] % 4 != 0) || ((addr_s[d] / 4) >= DEPTH) || (rd_s[d] && wr_s[d]);
          op_idx[d] = int'(addr_s[d] / 4);
          op_rd[d]  = op_err[d] ? 32'h0 : mmem[d][op_idx[d]];
        end
        mled[d] = led_next;
      end
    end
  end

  always @(negedge clock) begin
    bit exp_rdy;
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        exp_rdy = pend[d] && (cyc == acc[d] + lat_of(d) - 1);
        chk("m_ready", d, 32'(ready_o[d]), 32'(exp_rdy));
        chk("m_err", d, 32'(err_o[d]), 32'(exp_rdy && op_err[d]));
        if (!(exp_rdy && op_wr[d] && !op_err[d]))
          chk("m_rdata", d, rdata_o[d], (exp_rdy && !op_err[d]) ? op_rd[d] : 32'h0);
        chk("m_led", d, 32'(led_o[d]), 32'(mled[d]));
`ifdef DMEM_STATS_EN
        chk("m_rdcount", d, 32'(rdc_o[d]), 32'(mrdc[d]));
        chk("m_wrcount", d, 32'(wrc_o[d]), 32'(mwrc[d]));
`else
        chk("m_rdcount", d, 32'(rdc_o[d]), 32'h0);
        chk("m_wrcount", d, 32'(wrc_o[d]), 32'h0);
`endif
      end
    end
  end

  // Holds the request until ready, drops it, then idles over the commit edge.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat, output logic e,
                        output int n);
    rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wd_s[d] = wd;
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (ready_o[d]) break;
    end
    if (!ready_o[d]) chk("ready_timeout", d, 32'(ready_o[d]), 32'h1);
    rdat = rdata_o[d];
    e    = err_o[d];
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] r;
  logic        e;
  int          n;
  bit          saw;
  logic [31:0] ea [6];
  logic        er [6];
  logic        ew [6];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = 32'h0; wd_s[d] = 32'h0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_ready", 0, 32'(ready_o[0]), 32'h0);
    chk("rst_rdata", 0, rdata_o[0], 32'h0);
    chk("rst_err", 0, 32'(err_o[0]), 32'h0);
    chk("rst_led", 0, 32'(led_o[0]), 32'h0);
    chk("rst_rdcount", 0, 32'(rdc_o[0]), 32'h0);
    chk("rst_wrcount", 0, 32'(wrc_o[0]), 32'h0);

    access(0, 1'b1, 1'b0, 32'h8, 32'h0, r, e, n);
    chk("ld8_lat", 0, n, 2);
    chk("ld8_rdata", 0, r, 32'h0);
    chk("ld8_err", 0, 32'(e), 32'h0);

    for (int d = 0; d < 3; d++) begin
      access(d, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, n);
      chk("st10_lat", d, n, lat_of(d));
      chk("st10_err", d, 32'(e), 32'h0);
      access(d, 1'b1, 1'b0, 32'h10, 32'h0, r, e, n);
      chk("ld10_lat", d, n, lat_of(d));
      chk("ld10_rdata", d, r, 32'hDEADBEEF);
      chk("ld10_err", d, 32'(e), 32'h0);
    end

    access(0, 1'b0, 1'b1, 32'h0, 32'h0000000A, r, e, n);
    chk("led_at_commit", 0, 32'(led_o[0]), 32'h0);
    @(posedge clock); #1;
    chk("led_after", 0, 32'(led_o[0]), 32'hA);

    ea[0] = 32'h6;  er[0] = 1'b1; ew[0] = 1'b0;
    ea[1] = 32'h100; er[1] = 1'b1; ew[1] = 1'b0;
    ea[2] = 32'h10; er[2] = 1'b1; ew[2] = 1'b1;
    ea[3] = 32'h6;  er[3] = 1'b0; ew[3] = 1'b1;
    ea[4] = 32'h100; er[4] = 1'b0; ew[4] = 1'b1;
    ea[5] = 32'h40000010; er[5] = 1'b0; ew[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      access(0, er[k], ew[k], ea[k], 32'h12345678, r, e, n);
      chk("bad_err", k, 32'(e), 32'h1);
      chk("bad_rdata", k, r, 32'h0);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, r, e, n);
    chk("keep10", 0, r, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, r, e, n);
    chk("keep4", 0, r, 32'h0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, r, e, n);
    chk("keep0", 0, r, 32'h0000000A);

    rd_s[2] = 1'b0; wr_s[2] = 1'b1; addr_s[2] = 32'h20; wd_s[2] = 32'h11111111;
    saw = 1'b0;
    @(posedge clock); #1;
    saw = saw | ready_o[2];
    reset = 1'b1; wr_s[2] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      saw = saw | ready_o[2];
      @(posedge clock); #1;
    end
    chk("abort_no_ready", 2, 32'(saw), 32'h0);
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, r, e, n);
    chk("abort_word", 2, r, 32'h0);
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, r, e, n);
    chk("rst_cleared", 2, r, 32'h0);
    chk("rst_led0", 0, 32'(led_o[0]), 32'h0);

    access(0, 1'b0, 1'b1, 32'h4, 32'h1, r, e, n);
    access(0, 1'b0, 1'b1, 32'h8, 32'h2, r, e, n);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, r, e, n);
    chk("st_ld4", 0, r, 32'h1);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, r, e, n);
    chk("st_ld8", 0, r, 32'h2);
    access(0, 1'b1, 1'b0, 32'hC, 32'h0, r, e, n);
    access(0, 1'b1, 1'b0, 32'h3, 32'h0, r, e, n);
    chk("st_errload", 0, 32'(e), 32'h1);
`ifdef DMEM_STATS_EN
    chk("stats_rd", 0, 32'(rdc_o[0]), 32'd3);
    chk("stats_wr", 0, 32'(wrc_o[0]), 32'd2);
`else
    chk("stats_rd", 0, 32'(rdc_o[0]), 32'd0);
    chk("stats_wr", 0, 32'(wrc_o[0]), 32'd0);
`endif

    repeat (2) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
